fetch_resp_checker: RTL and testbench
=====================================

FETCH_RESP_CHECKER -- requirements
Module: fetch_resp_checker

Interface
REQ-001 SHALL have parameter FETCH_ADDR_WIDTH, default 32: fetch address width.
REQ-002 SHALL have parameter FETCH_DATA_WIDTH, default 32: fetch data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: depth of the pending-address queue, a power of two, at least 2.
REQ-004 SHALL have parameter DATA_XOR, default 32'h0000_0000: pattern XORed onto the address to form expected data.
REQ-005 SHALL have port clk  input  1  clock, rising edge active.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port clear_i  input  1  synchronous clear of counters, error capture and FAIL state.
REQ-008 SHALL have ports fetch_req_i, fetch_gnt_i, fetch_rvalid_i  input  1 each  passive taps on the core-side fetch handshake.
REQ-009 SHALL have port fetch_addr_i  input  FETCH_ADDR_WIDTH  tapped request address.
REQ-010 SHALL have port fetch_rdata_i  input  FETCH_DATA_WIDTH  tapped response data.
REQ-011 SHALL have ports n_req_o, n_rsp_o, n_err_o  output  32 each  granted-request, response and mismatch counts.
REQ-012 SHALL have port outstanding_o  output  $clog2(MAX_OUTSTANDING)+1  current pending-request count.
REQ-013 SHALL have port fail_o  output  1  sticky failure flag.
REQ-014 SHALL have ports err_addr_o  output  FETCH_ADDR_WIDTH, and err_rdata_o  output  FETCH_DATA_WIDTH  first-failure capture.
REQ-015 SHALL have port err_code_o  output  2  first-failure cause: 0 none, 1 data mismatch, 2 rvalid with nothing pending, 3 queue overflow.

Function
REQ-016 Accept event = fetch_req_i & fetch_gnt_i at a rising edge; this SHALL push fetch_addr_i into the in-order queue and increment n_req_o.
REQ-017 Response event = fetch_rvalid_i at a rising edge; this SHALL pop the queue head and increment n_rsp_o.
REQ-018 Expected data SHALL be the head address, zero-extended or truncated to FETCH_DATA_WIDTH, XOR DATA_XOR.
REQ-019 If rdata differs from expected, n_err_o SHALL increment.
REQ-020 Accept and response in the same cycle SHALL push and pop together; outstanding_o stays unchanged and the pop compares the old head.
REQ-021 Accept and response in the same cycle with an empty queue SHALL count as code 2; the push still takes effect.
REQ-022 A response with an empty queue, outside REQ-021, SHALL be code 2 with no pop.
REQ-023 An accept with the queue full and no simultaneous pop SHALL be code 3, with the push dropped.
REQ-024 The FSM SHALL have states RUN and FAIL; RUN->FAIL on the first error of any code, and FAIL->RUN only on clear_i or reset.
REQ-025 On RUN->FAIL, err_addr_o, err_rdata_o and err_code_o SHALL be captured; later errors update only n_err_o (all codes count).
REQ-026 Outputs SHALL be registered, with one cycle latency: values reflect events sampled at the previous edge.
REQ-027 Counters SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-028 The queue pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-029 clear_i SHALL zero counters, captures and fail_o, and force RUN, while the queue contents and outstanding_o are retained.
REQ-030 clear_i coincident with an event SHALL apply the clear first and then count the event.
REQ-031 The block SHALL never drive the fetch interface.

Reset
REQ-032 On rst_n low, immediately: all counters and outstanding_o 0, queue empty, fail_o 0, err_* 0, state RUN.
REQ-033 Reset asserted mid-transaction SHALL discard pending addresses; responses after reset with an empty queue are code 2.

Structure
REQ-034 Package icache_tb_pkg SHALL hold the err_code enum (ERR_NONE, ERR_MISMATCH, ERR_SPURIOUS, ERR_OVERFLOW), the checker state enum and the default DATA_XOR constant.
REQ-035 The address queue SHALL be a sub-module chk_addr_fifo with DEPTH and WIDTH parameters, push, pop, full, empty and count.

Verification
REQ-036 Single request at 0x0000_0100, gnt the same cycle, rvalid 2 cycles later with rdata 0x0000_0100 -> n_req 1, n_rsp 1, n_err 0, fail 0.
REQ-037 rvalid with rdata 0xDEAD_BEEF for pending address 0x0000_0FFC -> fail_o 1 one cycle later, err_code 1, err_addr 0x0FFC, err_rdata 0xDEADBEEF.
REQ-038 Back-to-back gnt plus rvalid every cycle for 1000 cycles with correct data -> outstanding stays 1, n_req 1000, n_rsp 999 or 1000, n_err 0.
REQ-039 5 accepts with no rvalid at MAX_OUTSTANDING 4 -> err_code 3, outstanding 4, fail_o 1.
REQ-040 rvalid after reset with no accept -> err_code 2; then pulse clear_i -> all outputs 0 and state RUN.
REQ-041 rst_n pulsed low with 3 pending -> outputs 0 asynchronously, and the next rvalid flags code 2.

Source files
------------

// File: rtl/fetch_resp_checker_pkg.sv
// Shared types and helpers for the fetch response checker: error causes,
// checker states, the default data pattern and a saturating counter step.
package icache_tb_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_SPURIOUS = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FAIL = 1'b1
  } chk_state_e;

  localparam logic [31:0] DEFAULT_DATA_XOR = 32'h0000_0000;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_resp_checker_if.sv
// Core-side instruction fetch handshake as seen by the checker.
// The checker only ever listens, so it takes the all-input modport.
interface fetch_resp_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_req_i;
  logic              fetch_gnt_i;
  logic              fetch_rvalid_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic [DATA_W-1:0] fetch_rdata_i;

  modport master (
    output fetch_req_i, fetch_gnt_i, fetch_rvalid_i, fetch_addr_i, fetch_rdata_i
  );

  modport slave (
    input fetch_req_i, fetch_gnt_i, fetch_rvalid_i, fetch_addr_i, fetch_rdata_i
  );
endinterface

// File: rtl/fetch_resp_checker_chk_addr_fifo.sv
// In-order queue of granted fetch addresses. Pushes into a full queue are
// dropped unless a pop frees a slot the same cycle; pops of an empty queue are ignored.
module chk_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = DEPTH;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    do_push  = push_i & ((count_q != CNT_FULL) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_resp_checker.sv
// Passive checker for the core-side fetch port: tracks granted addresses in
// order, compares each response against address ^ DATA_XOR, and latches the first failure.
module fetch_resp_checker
  import icache_tb_pkg::*;
#(
  parameter int                          FETCH_ADDR_WIDTH = 32,
  parameter int                          FETCH_DATA_WIDTH = 32,
  parameter int                          MAX_OUTSTANDING  = 4,
  parameter logic [FETCH_DATA_WIDTH-1:0] DATA_XOR         = FETCH_DATA_WIDTH'(DEFAULT_DATA_XOR)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear_i,
  fetch_resp_checker_if.slave                 fetch_if,
  output logic [31:0]                         n_req_o,
  output logic [31:0]                         n_rsp_o,
  output logic [31:0]                         n_err_o,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
  output logic                                fail_o,
  output logic [FETCH_ADDR_WIDTH-1:0]         err_addr_o,
  output logic [FETCH_DATA_WIDTH-1:0]         err_rdata_o,
  output logic [1:0]                          err_code_o
);

  logic                        accept, rsp;
  logic [FETCH_ADDR_WIDTH-1:0] addr, head;
  logic [FETCH_DATA_WIDTH-1:0] rdata, exp_data;
  logic                        fifo_full, fifo_empty;
  err_code_e                   err_now;

  chk_state_e                  state_q, state_d;
  logic [31:0]                 n_req_q, n_req_d;
  logic [31:0]                 n_rsp_q, n_rsp_d;
  logic [31:0]                 n_err_q, n_err_d;
  logic [FETCH_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [FETCH_DATA_WIDTH-1:0] err_rdata_q, err_rdata_d;
  err_code_e                   err_code_q, err_code_d;

  assign accept = fetch_if.fetch_req_i & fetch_if.fetch_gnt_i;
  assign rsp    = fetch_if.fetch_rvalid_i;
  assign addr   = fetch_if.fetch_addr_i;
  assign rdata  = fetch_if.fetch_rdata_i;

  chk_addr_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (FETCH_ADDR_WIDTH)
  ) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (rsp),
    .data_i  (addr),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  assign exp_data = FETCH_DATA_WIDTH'(head) ^ DATA_XOR;

  // A full queue can never be empty, so at most one cause fires per cycle.
  always_comb begin
    err_now = ERR_NONE;
    if (rsp && fifo_empty)                  err_now = ERR_SPURIOUS;
    else if (rsp && (rdata != exp_data))    err_now = ERR_MISMATCH;
    else if (accept && fifo_full && !rsp)   err_now = ERR_OVERFLOW;
  end

  always_comb begin
    state_d     = state_q;
    n_req_d     = n_req_q;
    n_rsp_d     = n_rsp_q;
    n_err_d     = n_err_q;
    err_addr_d  = err_addr_q;
    err_rdata_d = err_rdata_q;
    err_code_d  = err_code_q;

    // Clear takes effect first so a coincident event is still counted.
    if (clear_i) begin
      state_d     = ST_RUN;
      n_req_d     = '0;
      n_rsp_d     = '0;
      n_err_d     = '0;
      err_addr_d  = '0;
      err_rdata_d = '0;
      err_code_d  = ERR_NONE;
    end

    if (accept)              n_req_d = sat_inc(n_req_d);
    if (rsp)                 n_rsp_d = sat_inc(n_rsp_d);
    if (err_now != ERR_NONE) n_err_d = sat_inc(n_err_d);

    if ((err_now != ERR_NONE) && (state_d == ST_RUN)) begin
      state_d     = ST_FAIL;
      err_code_d  = err_now;
      err_addr_d  = (err_now == ERR_MISMATCH) ? head : addr;
      err_rdata_d = (err_now == ERR_OVERFLOW) ? '0 : rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      n_req_q     <= '0;
      n_rsp_q     <= '0;
      n_err_q     <= '0;
      err_addr_q  <= '0;
      err_rdata_q <= '0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      n_req_q     <= n_req_d;
      n_rsp_q     <= n_rsp_d;
      n_err_q     <= n_err_d;
      err_addr_q  <= err_addr_d;
      err_rdata_q <= err_rdata_d;
      err_code_q  <= err_code_d;
    end
  end

  assign n_req_o     = n_req_q;
  assign n_rsp_o     = n_rsp_q;
  assign n_err_o     = n_err_q;
  assign fail_o      = (state_q == ST_FAIL);
  assign err_addr_o  = err_addr_q;
  assign err_rdata_o = err_rdata_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_fetch_resp_checker.sv
// Scenario bench for fetch_resp_checker: granted addresses go into a scoreboard
// queue and are popped when responses are driven; counters are tracked alongside.
module tb_fetch_resp_checker;
  import icache_tb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int OW = $clog2(MO) + 1;
  localparam logic [DW-1:0] XOR = DEFAULT_DATA_XOR;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_i = 1'b0;
  always #5 clk = ~clk;

  fetch_resp_checker_if #(.ADDR_W(AW), .DATA_W(DW)) fif ();

  logic [31:0]   n_req, n_rsp, n_err;
  logic [OW-1:0] outstanding;
  logic          fail;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_rdata;
  logic [1:0]    err_code;

  fetch_resp_checker #(
    .FETCH_ADDR_WIDTH (AW),
    .FETCH_DATA_WIDTH (DW),
    .MAX_OUTSTANDING  (MO),
    .DATA_XOR         (XOR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (clear_i),
    .fetch_if      (fif.slave),
    .n_req_o       (n_req),
    .n_rsp_o       (n_rsp),
    .n_err_o       (n_err),
    .outstanding_o (outstanding),
    .fail_o        (fail),
    .err_addr_o    (err_addr),
    .err_rdata_o   (err_rdata),
    .err_code_o    (err_code)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] sb_q[$];
  logic [31:0]   m_req, m_rsp, m_err;

  function automatic logic [DW-1:0] exp_head();
    if (sb_q.size() == 0) return '0;
    return DW'(sb_q[0]) ^ XOR;
  endfunction

  task automatic model_clear();
    m_req = 0;
    m_rsp = 0;
    m_err = 0;
  endtask

  // One clock: drive the taps, let the edge happen, update the scoreboard, idle the taps.
  task automatic drive(input logic acc, input logic [AW-1:0] a, input logic rv, input logic [DW-1:0] rd);
    logic [DW-1:0] e;
    fif.fetch_req_i    = acc;
    fif.fetch_gnt_i    = acc;
    fif.fetch_addr_i   = a;
    fif.fetch_rvalid_i = rv;
    fif.fetch_rdata_i  = rd;
    @(posedge clk);
    if (clear_i) model_clear();
    if (rv) begin
      m_rsp++;
      if (sb_q.size() == 0) m_err++;
      else begin
        e = DW'(sb_q.pop_front()) ^ XOR;
        if (rd !== e) m_err++;
      end
    end
    if (acc) begin
      m_req++;
      if (sb_q.size() < MO) sb_q.push_back(a);
      else m_err++;
    end
    #1;
    fif.fetch_req_i    = 1'b0;
    fif.fetch_gnt_i    = 1'b0;
    fif.fetch_rvalid_i = 1'b0;
    clear_i            = 1'b0;
  endtask

  task automatic test_reset();
    fif.fetch_req_i = 1'b0; fif.fetch_gnt_i = 1'b0; fif.fetch_rvalid_i = 1'b0;
    fif.fetch_addr_i = '0; fif.fetch_rdata_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (n_req !== 32'd0) begin errors++; $display("FAIL reset_n_req got %0d want 0", n_req); end
    checks++;
    if (n_rsp !== 32'd0) begin errors++; $display("FAIL reset_n_rsp got %0d want 0", n_rsp); end
    checks++;
    if (n_err !== 32'd0) begin errors++; $display("FAIL reset_n_err got %0d want 0", n_err); end
    checks++;
    if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    checks++;
    if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b want 0", fail); end
    checks++;
    if (err_code !== 2'd0 || err_addr !== '0 || err_rdata !== '0) begin
      errors++; $display("FAIL reset_err got code %0d addr %h rdata %h want all 0", err_code, err_addr, err_rdata);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    model_clear();
    $display("reset: n_req %0d n_rsp %0d n_err %0d fail %b", n_req, n_rsp, n_err, fail);
  endtask

  task automatic test_single();
    drive(1'b1, 32'h0000_0100, 1'b0, '0);
    if (outstanding !== OW'(1)) begin errors++; $display("FAIL single_outstanding got %0d want 1", outstanding); end
    checks++;
    drive(1'b0, '0, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'h0000_0100);
    if (n_req !== 32'd1 || n_req !== m_req) begin errors++; $display("FAIL single_n_req got %0d want 1", n_req); end
    checks++;
    if (n_rsp !== 32'd1) begin errors++; $display("FAIL single_n_rsp got %0d want 1", n_rsp); end
    checks++;
    if (n_err !== 32'd0 || fail !== 1'b0) begin errors++; $display("FAIL single_err got n_err %0d fail %b want 0 0", n_err, fail); end
    checks++;
    $display("single: n_req %0d n_rsp %0d n_err %0d fail %b", n_req, n_rsp, n_err, fail);
  endtask

  task automatic test_mismatch();
    clear_i = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    drive(1'b1, 32'h0000_0FFC, 1'b0, '0);
    if (fail !== 1'b0) begin errors++; $display("FAIL mm_fail_early got %b want 0", fail); end
    checks++;
    drive(1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    if (fail !== 1'b1) begin errors++; $display("FAIL mm_fail got %b want 1", fail); end
    checks++;
    if (err_code !== 2'd1) begin errors++; $display("FAIL mm_code got %0d want 1", err_code); end
    checks++;
    if (err_addr !== 32'h0000_0FFC) begin errors++; $display("FAIL mm_addr got %h want 00000ffc", err_addr); end
    checks++;
    if (err_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mm_rdata got %h want deadbeef", err_rdata); end
    checks++;
    // A second failure counts but leaves the first capture in place.
    drive(1'b1, 32'h0000_0040, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'h0000_0041);
    if (n_err !== 32'd2 || n_err !== m_err) begin errors++; $display("FAIL mm_n_err got %0d want 2", n_err); end
    checks++;
    if (err_addr !== 32'h0000_0FFC || err_code !== 2'd1) begin
      errors++; $display("FAIL mm_sticky got addr %h code %0d want 00000ffc 1", err_addr, err_code);
    end
    checks++;
    $display("mismatch: fail %b code %0d addr %h rdata %h n_err %0d", fail, err_code, err_addr, err_rdata, n_err);
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    clear_i = 1'b1;
    drive(1'b1, 32'h0001_0000, 1'b0, '0);
    for (int i = 1; i < 1000; i++) begin
      drive(1'b1, $urandom() & 32'hFFFF_FFFC, 1'b1, exp_head());
      if (outstanding !== OW'(1)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL b2b_outstanding cycle %0d got %0d want 1", i, outstanding);
      end
      checks++;
    end
    if (n_req !== 32'd1000) begin errors++; $display("FAIL b2b_n_req got %0d want 1000", n_req); end
    checks++;
    if (n_rsp !== 32'd999) begin errors++; $display("FAIL b2b_n_rsp got %0d want 999", n_rsp); end
    checks++;
    if (n_err !== 32'd0 || fail !== 1'b0) begin errors++; $display("FAIL b2b_err got n_err %0d fail %b want 0 0", n_err, fail); end
    checks++;
    drive(1'b0, '0, 1'b1, exp_head());
    if (outstanding !== '0 || n_err !== m_err) begin
      errors++; $display("FAIL b2b_drain got outstanding %0d n_err %0d want 0 %0d", outstanding, n_err, m_err);
    end
    checks++;
    $display("back_to_back: n_req %0d n_rsp %0d n_err %0d", n_req, n_rsp, n_err);
  endtask

  task automatic test_overflow();
    clear_i = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0000_1000 + 32'(4 * i), 1'b0, '0);
    if (fail !== 1'b0 || outstanding !== OW'(MO)) begin
      errors++; $display("FAIL ovf_full got fail %b outstanding %0d want 0 %0d", fail, outstanding, MO);
    end
    checks++;
    drive(1'b1, 32'h0000_1010, 1'b0, '0);
    if (err_code !== 2'd3) begin errors++; $display("FAIL ovf_code got %0d want 3", err_code); end
    checks++;
    if (outstanding !== OW'(MO)) begin errors++; $display("FAIL ovf_outstanding got %0d want %0d", outstanding, MO); end
    checks++;
    if (fail !== 1'b1 || n_req !== 32'd5 || n_err !== 32'd1) begin
      errors++; $display("FAIL ovf_counts got fail %b n_req %0d n_err %0d want 1 5 1", fail, n_req, n_err);
    end
    checks++;
    // Full queue with a simultaneous pop accepts the push.
    drive(1'b1, 32'h0000_2000, 1'b1, exp_head());
    if (outstanding !== OW'(MO) || n_err !== 32'd1) begin
      errors++; $display("FAIL ovf_pushpop got outstanding %0d n_err %0d want %0d 1", outstanding, n_err, MO);
    end
    checks++;
    drive(1'b0, '0, 1'b1, exp_head());
    $display("overflow: code %0d outstanding %0d fail %b n_req %0d", err_code, outstanding, fail, n_req);
  endtask

  task automatic test_async_reset();
    if (outstanding !== OW'(3)) begin errors++; $display("FAIL areset_pending got %0d want 3", outstanding); end
    checks++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    if (outstanding !== '0 || n_req !== 32'd0 || n_err !== 32'd0) begin
      errors++; $display("FAIL areset_outs got outstanding %0d n_req %0d n_err %0d want 0 0 0", outstanding, n_req, n_err);
    end
    checks++;
    if (fail !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL areset_fail got fail %b code %0d want 0 0", fail, err_code); end
    checks++;
    sb_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 32'h0000_1004);
    if (err_code !== 2'd2 || fail !== 1'b1) begin errors++; $display("FAIL areset_spurious got code %0d fail %b want 2 1", err_code, fail); end
    checks++;
    if (outstanding !== '0 || n_err !== m_err) begin
      errors++; $display("FAIL areset_after got outstanding %0d n_err %0d want 0 %0d", outstanding, n_err, m_err);
    end
    checks++;
    $display("async_reset: code %0d fail %b outstanding %0d", err_code, fail, outstanding);
  endtask

  task automatic test_spurious_clear();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    model_clear();
    drive(1'b0, '0, 1'b1, 32'h1234_5678);
    if (err_code !== 2'd2 || fail !== 1'b1) begin errors++; $display("FAIL spur_code got %0d fail %b want 2 1", err_code, fail); end
    checks++;
    clear_i = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    if (n_req !== 0 || n_rsp !== 0 || n_err !== 0 || fail !== 1'b0 || err_code !== 2'd0 || err_addr !== '0 || err_rdata !== '0) begin
      errors++; $display("FAIL spur_clear got n_req %0d n_rsp %0d n_err %0d fail %b code %0d want all 0", n_req, n_rsp, n_err, fail, err_code);
    end
    checks++;
    // Accept and response together on an empty queue: flagged, but the push lands.
    drive(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200);
    if (err_code !== 2'd2 || outstanding !== OW'(1)) begin
      errors++; $display("FAIL spur_pushpop got code %0d outstanding %0d want 2 1", err_code, outstanding);
    end
    checks++;
    if (n_req !== m_req || n_rsp !== m_rsp || n_err !== m_err) begin
      errors++; $display("FAIL spur_counts got %0d %0d %0d want %0d %0d %0d", n_req, n_rsp, n_err, m_req, m_rsp, m_err);
    end
    checks++;
    // Clear with a coincident correct response: queue kept, response counted after clear.
    clear_i = 1'b1;
    drive(1'b0, '0, 1'b1, exp_head());
    if (n_rsp !== 32'd1 || n_req !== 32'd0 || n_err !== 32'd0 || fail !== 1'b0 || outstanding !== '0) begin
      errors++; $display("FAIL clr_event got n_rsp %0d n_req %0d n_err %0d fail %b outstanding %0d want 1 0 0 0 0",
                         n_rsp, n_req, n_err, fail, outstanding);
    end
    checks++;
    $display("spurious_clear: n_req %0d n_rsp %0d n_err %0d fail %b", n_req, n_rsp, n_err, fail);
  endtask

  initial begin
    test_reset();
    test_single();
    test_mismatch();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    test_spurious_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
